// File: rtl/tts_pkg.sv
// Shared types for the host programming block: FSM states and the buffered host write entry.
package tts_pkg;
  localparam int RAM_AW = 14;
  localparam int RAM_DW = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } hpb_state_t;

  typedef struct packed {
    logic [RAM_AW-1:0]   addr;
    logic [RAM_DW-1:0]   data;
    logic [RAM_DW/8-1:0] be;
  } hpb_wr_ent_t;
endpackage

// File: rtl/hpb_fifo.sv
// Synchronous FIFO buffering host writes; pointers wrap naturally since DEPTH is a power of 2.
module hpb_fifo #(
  parameter int WIDTH = 86,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  // Storage is not reset; pointer reset alone discards the contents.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/hpb.sv
// Host programming block: buffers host writes and issues them to rcb over a req/done handshake.
// state | meaning
// IDLE  | no request outstanding, waiting for a buffered write
// REQ   | request high, outputs frozen until rcb_wr_done
// DROP  | request low for one cycle so rcb re-arms
module hpb
  import tts_pkg::*;
#(
  parameter int RCB_RAM_WIDTH  = 64,
  parameter int HPB_FIFO_DEPTH = 4,
  parameter int HPB_TIMEOUT    = 1024
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       host_wr_valid,
  output logic                       host_wr_ready,
  input  logic [RAM_AW-1:0]          host_wr_addr,
  input  logic [RCB_RAM_WIDTH-1:0]   host_wr_data,
  input  logic [RCB_RAM_WIDTH/8-1:0] host_wr_be,
  output logic [RAM_AW-1:0]          hpb_wr_addr,
  output logic [RCB_RAM_WIDTH-1:0]   hpb_wr_data,
  output logic [RCB_RAM_WIDTH/8-1:0] hpb_wr_en,
  output logic                       hpb_wr_req,
  input  logic                       rcb_wr_done,
  output logic                       hpb_busy,
  output logic                       hpb_timeout,
  output logic [15:0]                hpb_wr_cnt
);
  localparam int BW = RCB_RAM_WIDTH / 8;
  localparam int EW = RAM_AW + RCB_RAM_WIDTH + BW;
  localparam int TW = $clog2(HPB_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LIM = TW'(HPB_TIMEOUT);

  hpb_state_t                   r_state;
  logic [RAM_AW-1:0]            r_addr;
  logic [RCB_RAM_WIDTH-1:0]     r_data;
  logic [BW-1:0]                r_en;
  logic [15:0]                  r_cnt;
  logic [TW-1:0]                r_to_cnt;
  logic                         r_timeout;
  logic                         r_live;
  logic                         w_push;
  logic                         w_pop;
  logic                         w_full;
  logic                         w_empty;
  logic [EW-1:0]                w_head;
  logic [$clog2(HPB_FIFO_DEPTH):0] w_count;

  // r_live keeps ready low through reset and releases it one edge later.
  assign host_wr_ready = r_live && !w_full;
  assign w_push        = host_wr_valid && host_wr_ready;
  assign w_pop         = !w_empty && (r_state == IDLE || r_state == DROP);

  hpb_fifo #(
    .WIDTH (EW),
    .DEPTH (HPB_FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_data  ({host_wr_addr, host_wr_data, host_wr_be}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_data    <= '0;
      r_en      <= '0;
      r_cnt     <= '0;
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
      r_live    <= 1'b0;
    end else begin
      r_live <= 1'b1;
      case (r_state)
        IDLE, DROP: begin
          if (!w_empty) begin
            {r_addr, r_data, r_en} <= w_head;
            r_to_cnt <= '0;
            r_state  <= REQ;
          end else begin
            r_state <= IDLE;
          end
        end
        REQ: begin
          // Saturating age; the flag is sticky and the request is never aborted.
          if (r_to_cnt != TO_LIM) r_to_cnt <= r_to_cnt + 1'b1;
          if (r_to_cnt == TO_LIM - TW'(1)) r_timeout <= 1'b1;
          if (rcb_wr_done) begin
            r_cnt   <= r_cnt + 1'b1;
            r_state <= DROP;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign hpb_wr_req  = (r_state == REQ);
  assign hpb_wr_addr = r_addr;
  assign hpb_wr_data = r_data;
  assign hpb_wr_en   = r_en;
  assign hpb_busy    = (w_count != '0) || (r_state != IDLE);
  assign hpb_timeout = r_timeout;
  assign hpb_wr_cnt  = r_cnt;
endmodule

// File: tb/tb_hpb.sv
// Self-checking bench for hpb: queue-based reference model, emulated rcb, directed and random traffic.
module tb_hpb;
  import tts_pkg::*;

  localparam int DEPTH = 4;
  localparam int TO    = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        host_wr_valid = 1'b0;
  logic        host_wr_ready;
  logic [13:0] host_wr_addr = '0;
  logic [63:0] host_wr_data = '0;
  logic [7:0]  host_wr_be = '0;
  logic [13:0] hpb_wr_addr;
  logic [63:0] hpb_wr_data;
  logic [7:0]  hpb_wr_en;
  logic        hpb_wr_req;
  logic        rcb_wr_done = 1'b0;
  logic        hpb_busy;
  logic        hpb_timeout;
  logic [15:0] hpb_wr_cnt;

  hpb #(
    .RCB_RAM_WIDTH  (64),
    .HPB_FIFO_DEPTH (DEPTH),
    .HPB_TIMEOUT    (TO)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .host_wr_valid (host_wr_valid),
    .host_wr_ready (host_wr_ready),
    .host_wr_addr  (host_wr_addr),
    .host_wr_data  (host_wr_data),
    .host_wr_be    (host_wr_be),
    .hpb_wr_addr   (hpb_wr_addr),
    .hpb_wr_data   (hpb_wr_data),
    .hpb_wr_en     (hpb_wr_en),
    .hpb_wr_req    (hpb_wr_req),
    .rcb_wr_done   (rcb_wr_done),
    .hpb_busy      (hpb_busy),
    .hpb_timeout   (hpb_timeout),
    .hpb_wr_cnt    (hpb_wr_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Reference model: pending writes, the write currently presented, and bookkeeping.
  hpb_wr_ent_t q[$];
  hpb_wr_ent_t m_cur = '0;
  bit          m_req = 1'b0;
  bit          m_gap = 1'b0;
  bit          m_live = 1'b0;
  bit          m_to = 1'b0;
  int          m_age = 0;
  logic [15:0] m_cnt = '0;
  logic [63:0] mem [bit [13:0]];

  bit blk_mode = 1'b0;
  int fixed_blk = 0;
  bit spur_rand = 1'b0;
  bit spur_force = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    hpb_wr_ent_t e;
    bit push;
    if (reset_n && rcb_wr_done && hpb_wr_req) begin
      logic [63:0] old;
      old = mem.exists(hpb_wr_addr) ? mem[hpb_wr_addr] : 64'h0;
      for (int b = 0; b < 8; b++)
        if (hpb_wr_en[b]) old[b*8 +: 8] = hpb_wr_data[b*8 +: 8];
      mem[hpb_wr_addr] = old;
    end
    if (!reset_n) begin
      q.delete();
      m_cur = '0; m_req = 0; m_gap = 0; m_live = 0; m_to = 0; m_age = 0; m_cnt = '0;
    end else begin
      push = host_wr_valid && m_live && (q.size() < DEPTH);
      if (m_req) begin
        m_age++;
        if (m_age == TO) m_to = 1;
        if (rcb_wr_done) begin
          m_cnt++;
          m_req = 0;
          m_gap = 1;
        end
      end else begin
        m_gap = 0;
        if (q.size() > 0) begin
          m_cur = q.pop_front();
          m_req = 1;
          m_age = 0;
        end
      end
      if (push) begin
        e.addr = host_wr_addr; e.data = host_wr_data; e.be = host_wr_be;
        q.push_back(e);
      end
      m_live = 1;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Emulated rcb: done arrives blk+1 cycles after the first request cycle.
  initial begin
    int  blk;
    bit  prev;
    blk = 0;
    prev = 0;
    forever begin
      @(posedge clk);
      #1;
      if (m_req && !prev)
        blk = blk_mode ? (($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 12))
                                                      : int'($urandom_range(0, 3)))
                       : fixed_blk;
      prev = m_req;
      if (m_req) rcb_wr_done = (m_age == blk + 1);
      else       rcb_wr_done = spur_force || (spur_rand && $urandom_range(0, 9) == 0);
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("ready",   host_wr_ready, m_live && (q.size() < DEPTH));
      chk("req",     hpb_wr_req, m_req);
      chk("addr",    hpb_wr_addr, m_cur.addr);
      chk("data",    hpb_wr_data, m_cur.data);
      chk("en",      hpb_wr_en, m_cur.be);
      chk("busy",    hpb_busy, (q.size() > 0) || m_req || m_gap);
      chk("timeout", hpb_timeout, m_to);
      chk("cnt",     hpb_wr_cnt, m_cnt);
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!hpb_busy) break;
    end
    chk("wait_idle", hpb_busy, 0);
    sync();
  endtask

  task automatic push_burst(input int n, input logic [13:0] base);
    int i = 0;
    int g = 0;
    bit rdy;
    while (i < n && g < 300) begin
      host_wr_valid = 1;
      host_wr_addr  = base + 14'(i);
      host_wr_data  = {$urandom, $urandom};
      host_wr_be    = (i == 2) ? 8'h00 : 8'(($urandom_range(1, 255)));
      @(negedge clk);
      rdy = host_wr_ready;
      sync();
      if (rdy) i++;
      g++;
    end
    host_wr_valid = 0;
    chk("push_burst_done", i, n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int got;
    int tlist[5];
    logic [13:0] alist[5];

    reset_n = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1;
    @(negedge clk);
    chk("rst_ready", host_wr_ready, 0);
    chk("rst_req",   hpb_wr_req, 0);
    chk("rst_addr",  hpb_wr_addr, 0);
    chk("rst_busy",  hpb_busy, 0);
    chk("rst_cnt",   hpb_wr_cnt, 0);
    sync();
    reset_n = 1;
    sync();
    chk("ready_after_rst", host_wr_ready, 1);

    // Single unblocked write: req high in the 2nd and 3rd cycles after the push edge.
    fixed_blk = 0;
    host_wr_valid = 1; host_wr_addr = 14'h0123;
    host_wr_data = 64'hDEADBEEF_CAFEF00D; host_wr_be = 8'hFF;
    sync();
    host_wr_valid = 0;
    @(negedge clk); chk("single_c1_req", hpb_wr_req, 0);
    @(negedge clk); chk("single_c2_req", hpb_wr_req, 1);
    chk("single_c2_addr", hpb_wr_addr, 14'h0123);
    @(negedge clk); chk("single_c3_req", hpb_wr_req, 1);
    chk("single_c3_data", hpb_wr_data, 64'hDEADBEEF_CAFEF00D);
    @(negedge clk); chk("single_c4_req", hpb_wr_req, 0);
    chk("single_cnt", hpb_wr_cnt, 1);
    chk("single_mem", mem.exists(14'h0123) ? mem[14'h0123] : 64'h0, 64'hDEADBEEF_CAFEF00D);

    // Blocked 10 cycles with zero byte enables: 12 req cycles, timeout sets in cycle 9.
    fixed_blk = 10;
    sync();
    host_wr_valid = 1; host_wr_addr = 14'h0200; host_wr_data = {$urandom, $urandom}; host_wr_be = 8'h00;
    sync();
    host_wr_valid = 0;
    n = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (hpb_wr_req) begin
        n++;
        if (n == TO)     chk("to_before", hpb_timeout, 0);
        if (n == TO + 1) chk("to_after", hpb_timeout, 1);
      end else if (n > 0) break;
    end
    chk("blocked_req_len", n, 12);
    chk("blocked_cnt", hpb_wr_cnt, 2);

    // Burst of 5, rcb unblocked: in-order, one write every 3 cycles.
    fixed_blk = 0;
    wait_idle();
    got = 0;
    fork
      push_burst(5, 14'h0300);
      for (int c = 0; c < 80 && got < 5; c++) begin
        @(negedge clk);
        if (hpb_wr_req && rcb_wr_done) begin
          tlist[got] = c;
          alist[got] = hpb_wr_addr;
          got++;
        end
      end
    join
    chk("burst_got", got, 5);
    for (int i = 0; i < 5; i++) chk("burst_order", alist[i], 14'h0300 + 14'(i));
    for (int i = 1; i < 5; i++) chk("burst_cadence", tlist[i] - tlist[i-1], 3);
    sync();
    chk("burst_cnt", hpb_wr_cnt, 7);

    // Long blocking fills the FIFO: ready drops once four entries are queued behind the active one.
    fixed_blk = 20;
    wait_idle();
    push_burst(5, 14'h0400);
    chk("full_ready", host_wr_ready, 0);
    chk("full_busy", hpb_busy, 1);
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (hpb_wr_cnt == 16'd12) break;
    end
    chk("full_cnt", hpb_wr_cnt, 12);
    chk("timeout_sticky", hpb_timeout, 1);

    // Spurious done while idle is ignored.
    fixed_blk = 0;
    wait_idle();
    @(negedge clk);
    spur_force = 1;
    @(posedge clk);
    #3;
    spur_force = 0;
    @(negedge clk);
    @(negedge clk);
    chk("spur_cnt", hpb_wr_cnt, 12);
    chk("spur_req", hpb_wr_req, 0);
    chk("spur_busy", hpb_busy, 0);

    // Random traffic with random rcb latency and stray done pulses.
    sync();
    blk_mode = 1;
    spur_rand = 1;
    repeat (1500) begin
      host_wr_valid = ($urandom_range(0, 1) == 1);
      host_wr_addr  = 14'($urandom);
      host_wr_data  = {$urandom, $urandom};
      host_wr_be    = 8'($urandom);
      sync();
    end
    host_wr_valid = 0;
    spur_rand = 0;
    blk_mode = 0;
    fixed_blk = 0;
    wait_idle();

    // Reset while a request is held with two entries queued.
    fixed_blk = 1000;
    push_burst(3, 14'h0500);
    chk("prerst_req", hpb_wr_req, 1);
    chk("prerst_busy", hpb_busy, 1);
    reset_n = 0;
    sync();
    reset_n = 1;
    @(negedge clk);
    chk("postrst_req", hpb_wr_req, 0);
    chk("postrst_cnt", hpb_wr_cnt, 0);
    chk("postrst_busy", hpb_busy, 0);
    chk("postrst_ready", host_wr_ready, 0);
    chk("postrst_timeout", hpb_timeout, 0);
    repeat (20) begin
      @(negedge clk);
      chk("postrst_idle_req", hpb_wr_req, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
